robo_missao: RTL and testbench

ROBO_MISSAO -- requirements
Module: robo_missao

---
 rtl/robo_pkg.sv | 41 ++++
 rtl/robo_pose.sv | 34 +++
 rtl/robo_missao.sv | 156 +++++++++++++++
 tb/tb_robo_missao.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/robo_pkg.sv
// Shared types and constants for the mission controller and its pose datapath.
package robo_pkg;

    typedef enum logic [1:0] {
        ORI_N = 2'b00,
        ORI_S = 2'b01,
        ORI_L = 2'b10,
        ORI_O = 2'b11
    } ori_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        STS_LOOP   = 2'b00,
        STS_BUDGET = 2'b01,
        STS_OOB    = 2'b10,
        STS_STALL  = 2'b11
    } status_t;

    localparam logic [3:0] LIN_MIN   = 4'd1;
    localparam logic [3:0] LIN_MAX   = 4'd10;
    localparam logic [4:0] COL_MAX   = 5'd19;
    localparam logic [4:0] STALL_MAX = 5'd16;

    // Left turn: N->O, O->S, S->L, L->N.
    function automatic ori_t turn_left(input ori_t o);
        case (o)
            ORI_N:   return ORI_O;
            ORI_O:   return ORI_S;
            ORI_S:   return ORI_L;
            default: return ORI_N;
        endcase
    endfunction

endpackage

// File: rtl/robo_pose.sv
// Combinational next-pose for one action; a forward that would leave the grid
// keeps the pose and raises oob instead.
module robo_pose
    import robo_pkg::*;
(
    input  logic [3:0] lin,
    input  logic [4:0] col,
    input  ori_t       ori,
    input  logic       forward,
    input  logic       turn,
    output logic [3:0] lin_nxt,
    output logic [4:0] col_nxt,
    output ori_t       ori_nxt,
    output logic       oob
);

    always_comb begin
        lin_nxt = lin;
        col_nxt = col;
        ori_nxt = ori;
        oob     = 1'b0;
        if (forward) begin
            case (ori)
                ORI_N: if (lin <= LIN_MIN) oob = 1'b1; else lin_nxt = lin - 4'd1;
                ORI_S: if (lin >= LIN_MAX) oob = 1'b1; else lin_nxt = lin + 4'd1;
                ORI_L: if (col >= COL_MAX) oob = 1'b1; else col_nxt = col + 5'd1;
                default: if (col == 5'd0) oob = 1'b1; else col_nxt = col - 5'd1;
            endcase
        end else if (turn) begin
            ori_nxt = turn_left(ori);
        end
    end

endmodule

// File: rtl/robo_missao.sv
// Mission supervisor: holds the Robo core in reset outside RUN, tracks its pose
// from the action outputs and ends the mission on loop, budget, bounds or stall.
module robo_missao
    import robo_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  lin_ini,
    input  logic [4:0]  col_ini,
    input  logic [1:0]  ori_ini,
    input  logic [23:0] limite,
    input  logic        forward,
    input  logic        turn,
    input  logic        remove,
    output logic        core_reset,
    output logic [3:0]  lin,
    output logic [4:0]  col,
    output logic [1:0]  ori,
    output logic [23:0] movimentos,
    output logic [7:0]  remocoes,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status,
    output state_t      fsm_state
);

    // Protocol: start is a one-cycle pulse honoured only in IDLE/DONE/FAULT;
    // forward/turn/remove are sampled once per cycle only in RUN, in that priority.
    state_t      state_q, state_d;
    logic [3:0]  lin_q, lin0_q, lin_p;
    logic [4:0]  col_q, col0_q, col_p;
    ori_t        ori_q, ori0_q, ori_p;
    logic [23:0] limite_q, mov_q, mov_inc;
    logic [7:0]  rem_q;
    logic [4:0]  stall_q;
    logic        moved_q, moved_d;
    status_t     status_q;
    logic        act, oob, loop_hit, budget_hit, stall_hit, start_ok;

    robo_pose u_pose (
        .lin     (lin_q),
        .col     (col_q),
        .ori     (ori_q),
        .forward (forward),
        .turn    (turn),
        .lin_nxt (lin_p),
        .col_nxt (col_p),
        .ori_nxt (ori_p),
        .oob     (oob)
    );

    assign act        = forward | turn | remove;
    assign mov_inc    = mov_q + 24'd1;
    assign moved_d    = moved_q | (forward & ~oob);
    assign loop_hit   = moved_d && (lin_p == lin0_q) && (col_p == col0_q) && (ori_p == ori0_q);
    assign budget_hit = (mov_inc == limite_q);
    assign stall_hit  = (stall_q == STALL_MAX - 5'd1);
    assign start_ok   = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_FAULT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_FAULT: if (start) state_d = ST_ARM;
            ST_ARM: state_d = (limite_q == 24'd0) ? ST_DONE : ST_RUN;
            ST_RUN: begin
                if (act) begin
                    if (oob)             state_d = ST_FAULT;
                    else if (loop_hit)   state_d = ST_DONE;
                    else if (budget_hit) state_d = ST_DONE;
                end else if (stall_hit) begin
                    state_d = ST_FAULT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        core_reset = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_ARM:   busy = 1'b1;
            ST_RUN: begin
                busy       = 1'b1;
                core_reset = 1'b0;
            end
            ST_DONE, ST_FAULT: done = 1'b1;
            default: ;
        endcase
    end

    // Pose, counters and status; everything freezes outside ARM/RUN until restarted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lin_q    <= LIN_MIN;
            col_q    <= 5'd0;
            ori_q    <= ORI_N;
            lin0_q   <= LIN_MIN;
            col0_q   <= 5'd0;
            ori0_q   <= ORI_N;
            limite_q <= 24'd0;
            mov_q    <= 24'd0;
            rem_q    <= 8'd0;
            stall_q  <= 5'd0;
            moved_q  <= 1'b0;
            status_q <= STS_LOOP;
        end else if (start_ok) begin
            lin_q    <= lin_ini;
            col_q    <= col_ini;
            ori_q    <= ori_t'(ori_ini);
            lin0_q   <= lin_ini;
            col0_q   <= col_ini;
            ori0_q   <= ori_t'(ori_ini);
            limite_q <= limite;
            mov_q    <= 24'd0;
            rem_q    <= 8'd0;
            stall_q  <= 5'd0;
            moved_q  <= 1'b0;
            status_q <= STS_LOOP;
        end else if (state_q == ST_ARM) begin
            if (limite_q == 24'd0) status_q <= STS_BUDGET;
        end else if (state_q == ST_RUN) begin
            if (act) begin
                mov_q   <= mov_inc;
                stall_q <= 5'd0;
                lin_q   <= lin_p;
                col_q   <= col_p;
                ori_q   <= ori_p;
                moved_q <= moved_d;
                if (remove && !forward && !turn && rem_q != 8'hFF) rem_q <= rem_q + 8'd1;
                if (oob)             status_q <= STS_OOB;
                else if (loop_hit)   status_q <= STS_LOOP;
                else if (budget_hit) status_q <= STS_BUDGET;
            end else begin
                stall_q <= stall_q + 5'd1;
                if (stall_hit) status_q <= STS_STALL;
            end
        end
    end

    assign lin        = lin_q;
    assign col        = col_q;
    assign ori        = ori_q;
    assign movimentos = mov_q;
    assign remocoes   = rem_q;
    assign status     = status_q;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_robo_missao.sv
// Bench for robo_missao: table of directed missions, hand-written corner
// sequences and random missions checked against a rule-level mission model.
module tb_robo_missao;
    import robo_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  lin_ini = 4'd1;
    logic [4:0]  col_ini = 5'd0;
    logic [1:0]  ori_ini = 2'd0;
    logic [23:0] limite = 24'd0;
    logic        forward = 1'b0, turn = 1'b0, remove = 1'b0;
    logic        core_reset, busy, done;
    logic [3:0]  lin;
    logic [4:0]  col;
    logic [1:0]  ori, status;
    logic [23:0] movimentos;
    logic [7:0]  remocoes;
    state_t      fsm_state;

    robo_missao dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .lin_ini    (lin_ini),
        .col_ini    (col_ini),
        .ori_ini    (ori_ini),
        .limite     (limite),
        .forward    (forward),
        .turn       (turn),
        .remove     (remove),
        .core_reset (core_reset),
        .lin        (lin),
        .col        (col),
        .ori        (ori),
        .movimentos (movimentos),
        .remocoes   (remocoes),
        .busy       (busy),
        .done       (done),
        .status     (status),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic core_low_seen = 1'b0;
    always @(negedge clock) if (reset && !core_reset) core_low_seen = 1'b1;

    // ---------------- scoreboard ----------------
    typedef logic [44:0] res_t;   // {status, lin, col, ori, movimentos, remocoes}
    res_t       exp_q[$];
    logic [2:0] act_q[$];         // {forward, turn, remove} per RUN cycle
    int n_checks = 0;
    int n_pass   = 0;

    int dr[4]      = '{-1, 1, 0, 0};
    int dc[4]      = '{0, 0, 1, -1};
    int left_of[4] = '{3, 2, 0, 1};

    typedef struct {
        logic [3:0]  lin;
        logic [4:0]  col;
        logic [1:0]  ori;
        logic [23:0] limite;
        string       acts;
        logic [1:0]  e_status;
        logic [3:0]  e_lin;
        logic [4:0]  e_col;
        logic [1:0]  e_ori;
        logic [23:0] e_mov;
        logic [7:0]  e_rem;
    } vec_t;
    vec_t vecs[13];

    function automatic res_t pack_res(input logic [1:0] s, input logic [3:0] l, input logic [4:0] c,
                                      input logic [1:0] o, input logic [23:0] m, input logic [7:0] r);
        return {s, l, c, o, m, r};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, want);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // F=forward T=turn R=remove A=all three X=turn+remove '-'=idle
    task automatic load_acts(input string s);
        byte ch;
        act_q.delete();
        for (int i = 0; i < s.len(); i++) begin
            ch = s[i];
            if (ch == "F")      act_q.push_back(3'b100);
            else if (ch == "T") act_q.push_back(3'b010);
            else if (ch == "R") act_q.push_back(3'b001);
            else if (ch == "A") act_q.push_back(3'b111);
            else if (ch == "X") act_q.push_back(3'b011);
            else                act_q.push_back(3'b000);
        end
    endtask

    // Mission rules applied to the action list, idling forever after it runs out.
    task automatic model(input int l, input int c, input int o, input int lim, output res_t r);
        int row, cl, dir, mov, rem, idle, st, nr, nc;
        bit moved;
        logic [2:0] a;
        row = l; cl = c; dir = o; mov = 0; rem = 0; idle = 0; st = -1; moved = 0;
        if (lim == 0) st = 1;
        for (int k = 0; st < 0 && k < 5000; k++) begin
            a = (k < act_q.size()) ? act_q[k] : 3'b000;
            if (a == 3'b000) begin
                idle++;
                if (idle == 16) st = 3;
            end else begin
                idle = 0;
                mov++;
                if (a[2]) begin
                    nr = row + dr[dir];
                    nc = cl + dc[dir];
                    if (nr < 1 || nr > 10 || nc < 0 || nc > 19) st = 2;
                    else begin row = nr; cl = nc; moved = 1; end
                end else if (a[1]) begin
                    dir = left_of[dir];
                end else if (rem < 255) begin
                    rem++;
                end
                if (st < 0) begin
                    if (moved && row == l && cl == c && dir == o) st = 0;
                    else if (mov == lim) st = 1;
                end
            end
        end
        r = {2'(st), 4'(row), 5'(cl), 2'(dir), 24'(mov), 8'(rem)};
    endtask

    // ---------------- driver ----------------
    task automatic run_mission(input logic [3:0] l, input logic [4:0] c, input logic [1:0] o,
                               input logic [23:0] lim, input int glitch_idx, input string tag);
        int k;
        res_t e;
        logic [2:0] a;
        lin_ini = l; col_ini = c; ori_ini = o; limite = lim;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, " arm busy"}, busy, 1);
        chk({tag, " arm state"}, fsm_state, ST_ARM);
        step();
        k = 0;
        while (!done && k < 2000) begin
            a = (act_q.size() > 0) ? act_q.pop_front() : 3'b000;
            {forward, turn, remove} = a;
            if (k == glitch_idx) begin
                start = 1'b1; lin_ini = 4'd9; col_ini = 5'd9; ori_ini = 2'd1;
            end
            step();
            start = 1'b0;
            k++;
        end
        {forward, turn, remove} = 3'b000;
        chk({tag, " finished"}, done, 1);
        if (exp_q.size() == 0) begin
            $display("FAIL %s: expected queue empty", tag);
            n_checks++;
        end else begin
            e = exp_q.pop_front();
            chk({tag, " status"}, status, e[44:43]);
            chk({tag, " lin"}, lin, e[42:39]);
            chk({tag, " col"}, col, e[38:34]);
            chk({tag, " ori"}, ori, e[33:32]);
            chk({tag, " movimentos"}, movimentos, e[31:8]);
            chk({tag, " remocoes"}, remocoes, e[7:0]);
            chk({tag, " busy"}, busy, 0);
            chk({tag, " core_reset"}, core_reset, 1);
            chk({tag, " state"}, fsm_state, (e[44:43] >= 2'd2) ? ST_FAULT : ST_DONE);
        end
    endtask

    // ---------------- test ----------------
    initial begin
        res_t r;
        int l, c, o, lim, n;

        vecs[0]  = '{4'd5, 5'd3, 2'd2, 24'd100, "FTTTT", 2'd3, 4'd5, 5'd4, 2'd2, 24'd5, 8'd0};
        vecs[1]  = '{4'd1, 5'd0, 2'd0, 24'd100, "F", 2'd2, 4'd1, 5'd0, 2'd0, 24'd1, 8'd0};
        vecs[2]  = '{4'd2, 5'd2, 2'd2, 24'd100, "FTFTFTFT", 2'd0, 4'd2, 5'd2, 2'd2, 24'd8, 8'd0};
        vecs[3]  = '{4'd2, 5'd2, 2'd2, 24'd8, "FTFTFTFT", 2'd0, 4'd2, 5'd2, 2'd2, 24'd8, 8'd0};
        vecs[4]  = '{4'd2, 5'd2, 2'd2, 24'd5, "FTFTFTFT", 2'd1, 4'd1, 5'd2, 2'd3, 24'd5, 8'd0};
        vecs[5]  = '{4'd4, 5'd4, 2'd1, 24'd0, "F", 2'd1, 4'd4, 5'd4, 2'd1, 24'd0, 8'd0};
        vecs[6]  = '{4'd5, 5'd5, 2'd0, 24'd1, "A", 2'd1, 4'd4, 5'd5, 2'd0, 24'd1, 8'd0};
        vecs[7]  = '{4'd10, 5'd7, 2'd1, 24'd100, "RRF", 2'd2, 4'd10, 5'd7, 2'd1, 24'd3, 8'd2};
        vecs[8]  = '{4'd3, 5'd19, 2'd2, 24'd100, "F", 2'd2, 4'd3, 5'd19, 2'd2, 24'd1, 8'd0};
        vecs[9]  = '{4'd3, 5'd0, 2'd3, 24'd100, "F", 2'd2, 4'd3, 5'd0, 2'd3, 24'd1, 8'd0};
        vecs[10] = '{4'd6, 5'd6, 2'd3, 24'd2, "XR", 2'd1, 4'd6, 5'd6, 2'd1, 24'd2, 8'd1};
        vecs[11] = '{4'd7, 5'd7, 2'd0, 24'd100, "F---------------T", 2'd3, 4'd6, 5'd7, 2'd3, 24'd2, 8'd0};
        vecs[12] = '{4'd3, 5'd3, 2'd0, 24'd100, "TTTTF", 2'd3, 4'd2, 5'd3, 2'd0, 24'd5, 8'd0};

        // Reset values
        step();
        step();
        chk("rst state", fsm_state, ST_IDLE);
        chk("rst core_reset", core_reset, 1);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst status", status, 0);
        chk("rst lin", lin, 1);
        chk("rst col", col, 0);
        chk("rst ori", ori, 0);
        chk("rst movimentos", movimentos, 0);
        chk("rst remocoes", remocoes, 0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 13; i++) begin
            load_acts(vecs[i].acts);
            exp_q.push_back(pack_res(vecs[i].e_status, vecs[i].e_lin, vecs[i].e_col,
                                     vecs[i].e_ori, vecs[i].e_mov, vecs[i].e_rem));
            run_mission(vecs[i].lin, vecs[i].col, vecs[i].ori, vecs[i].limite, -1,
                        $sformatf("vec%0d", i));
        end

        // Remove count saturates
        act_q.delete();
        for (int i = 0; i < 300; i++) act_q.push_back(3'b001);
        exp_q.push_back(pack_res(2'd3, 4'd5, 5'd5, 2'd0, 24'd300, 8'd255));
        run_mission(4'd5, 5'd5, 2'd0, 24'd1000, -1, "sat");

        // start pulsed during RUN is ignored; final values then hold in DONE
        load_acts("FTFTFTFT");
        exp_q.push_back(pack_res(2'd0, 4'd2, 5'd2, 2'd2, 24'd8, 8'd0));
        run_mission(4'd2, 5'd2, 2'd2, 24'd100, 2, "glitch");
        step(); step(); step();
        chk("hold status", status, 0);
        chk("hold movimentos", movimentos, 8);
        chk("hold done", done, 1);

        // limite 0 never releases the core
        core_low_seen = 1'b0;
        act_q.delete();
        exp_q.push_back(pack_res(2'd1, 4'd8, 5'd12, 2'd3, 24'd0, 8'd0));
        run_mission(4'd8, 5'd12, 2'd3, 24'd0, -1, "lim0");
        chk("lim0 core_reset low seen", core_low_seen, 0);

        // Reset mid-RUN
        lin_ini = 4'd5; col_ini = 5'd5; ori_ini = 2'd0; limite = 24'd100;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        forward = 1'b1;
        step();
        step();
        forward = 1'b0;
        chk("midrun pre lin", lin, 3);
        chk("midrun pre movimentos", movimentos, 2);
        #2 reset = 1'b0;
        #1;
        chk("midrun async lin", lin, 1);
        chk("midrun async movimentos", movimentos, 0);
        chk("midrun async core_reset", core_reset, 1);
        step();
        chk("midrun state", fsm_state, ST_IDLE);
        chk("midrun busy", busy, 0);
        chk("midrun done", done, 0);
        chk("midrun status", status, 0);
        chk("midrun col", col, 0);
        chk("midrun ori", ori, 0);
        chk("midrun remocoes", remocoes, 0);
        reset = 1'b1;
        step();

        // Random missions against the model
        for (int m = 0; m < 40; m++) begin
            l = $urandom_range(1, 10);
            c = $urandom_range(0, 19);
            o = $urandom_range(0, 3);
            lim = $urandom_range(0, 24);
            n = $urandom_range(0, 30);
            act_q.delete();
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 9) < 3) act_q.push_back(3'b000);
                else act_q.push_back(3'($urandom_range(1, 7)));
            end
            model(l, c, o, lim, r);
            exp_q.push_back(r);
            run_mission(4'(l), 5'(c), 2'(o), 24'(lim), -1, $sformatf("rnd%0d", m));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
